// File: rtl/p_beid_peripheral_f0_id_pkg.sv
// Shared definitions for the peripheral identification-space reader.
//   - Word indices (paddr[11:2]) of the PID/CID registers at 0xFD0-0xFFC
//   - Fixed CoreSight-style component ID bytes
//   - Transfer FSM state type and the wait-state counter width
package p_beid_peripheral_f0_id_pkg;

    // Wait-state counter width; WAIT_STATES is limited to 0..3.
    localparam int WS_W = 2;

    // Word indices: byte offset >> 2.
    localparam logic [9:0] ID_PID4_OFS = 10'h3F4;  // 0xFD0
    localparam logic [9:0] ID_PID5_OFS = 10'h3F5;  // 0xFD4
    localparam logic [9:0] ID_PID6_OFS = 10'h3F6;  // 0xFD8
    localparam logic [9:0] ID_PID7_OFS = 10'h3F7;  // 0xFDC
    localparam logic [9:0] ID_PID0_OFS = 10'h3F8;  // 0xFE0
    localparam logic [9:0] ID_PID1_OFS = 10'h3F9;  // 0xFE4
    localparam logic [9:0] ID_PID2_OFS = 10'h3FA;  // 0xFE8
    localparam logic [9:0] ID_PID3_OFS = 10'h3FB;  // 0xFEC
    localparam logic [9:0] ID_CID0_OFS = 10'h3FC;  // 0xFF0
    localparam logic [9:0] ID_CID1_OFS = 10'h3FD;  // 0xFF4
    localparam logic [9:0] ID_CID2_OFS = 10'h3FE;  // 0xFF8
    localparam logic [9:0] ID_CID3_OFS = 10'h3FF;  // 0xFFC

    // Component ID preamble bytes.
    localparam logic [7:0] CID0_VAL = 8'h0D;
    localparam logic [7:0] CID1_VAL = 8'hF0;
    localparam logic [7:0] CID2_VAL = 8'h05;
    localparam logic [7:0] CID3_VAL = 8'hB1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

endpackage

// File: rtl/p_beid_peripheral_f0_id_rom.sv
// Combinational decode of the identification space.
// Ports:
//   word_idx - paddr[11:2] of the access
//   eco      - snapshotted ECO revision nibble (returned in PID3[7:4])
//   data     - 8-bit ID byte; 0 for any offset outside the ID map
module p_beid_peripheral_f0_id_rom
    import p_beid_peripheral_f0_id_pkg::*;
#(
    parameter logic [11:0] PART_NUM    = 12'h820,
    parameter logic [6:0]  JEP106_ID   = 7'h3B,
    parameter logic [3:0]  JEP106_CONT = 4'h4,
    parameter logic [3:0]  REVISION    = 4'h0,
    parameter logic [3:0]  REVAND      = 4'h0
) (
    input  logic [9:0] word_idx,
    input  logic [3:0] eco,
    output logic [7:0] data
);

    // NOTE: every output of a combinational block gets a default before the
    // case so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        data = 8'h00;
        unique case (word_idx)
            ID_PID4_OFS: data = {4'h0, JEP106_CONT};
            ID_PID0_OFS: data = PART_NUM[7:0];
            ID_PID1_OFS: data = {JEP106_ID[3:0], PART_NUM[11:8]};
            ID_PID2_OFS: data = {REVISION, 1'b1, JEP106_ID[6:4]};
            ID_PID3_OFS: data = {eco, REVAND};
            ID_CID0_OFS: data = CID0_VAL;
            ID_CID1_OFS: data = CID1_VAL;
            ID_CID2_OFS: data = CID2_VAL;
            ID_CID3_OFS: data = CID3_VAL;
            default:     data = 8'h00;  // PID5-7 and unmapped offsets
        endcase
    end

endmodule

// File: rtl/p_beid_peripheral_f0_id_reader.sv
// APB3 completer for the peripheral ID space (PID4-7, PID0-3, CID0-3).
// The ECO revision nibble is snapshotted from a static input into eco_q and
// returned in PID3; everything else comes from parameters. All outputs are
// registered; pready is high whenever no transfer is stretching.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   psel/penable/pwrite - APB control; paddr[11:2] decoded, pwdata ignored
//   ecorevnum           - static ECO revision nibble
//   eco_resample        - one-cycle request to re-capture ecorevnum
//   prdata/pready/pslverr - APB response
module p_beid_peripheral_f0_id_reader
    import p_beid_peripheral_f0_id_pkg::*;
#(
    parameter int unsigned WAIT_STATES  = 0,  // 0..3
    parameter logic [11:0] PART_NUM     = 12'h820,
    parameter logic [6:0]  JEP106_ID    = 7'h3B,
    parameter logic [3:0]  JEP106_CONT  = 4'h4,
    parameter logic [3:0]  REVISION     = 4'h0,
    parameter logic [3:0]  REVAND       = 4'h0,
    parameter bit          ERR_ON_WRITE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [11:0] paddr,
    input  logic [31:0] pwdata,
    input  logic [3:0]  ecorevnum,
    input  logic        eco_resample,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    localparam logic [WS_W-1:0] WS_INIT = WS_W'(WAIT_STATES);

    state_e          state_q, state_d;
    logic [WS_W-1:0] cnt_q, cnt_d;
    logic            pwrite_q, pwrite_d;
    logic [7:0]      prdata_q, prdata_d;
    logic            pready_q, pready_d;
    logic            pslverr_q, pslverr_d;
    logic [3:0]      eco_q, eco_d;
    logic            capture_pending_q, capture_pending_d;

    logic       setup;
    logic [7:0] rom_data;

    // Write data and byte-lane bits carry no meaning for a read-only space.
    logic unused_inputs;
    assign unused_inputs = ^{pwdata, paddr[1:0]};

    assign setup = psel & ~penable;

    p_beid_peripheral_f0_id_rom #(
        .PART_NUM    (PART_NUM),
        .JEP106_ID   (JEP106_ID),
        .JEP106_CONT (JEP106_CONT),
        .REVISION    (REVISION),
        .REVAND      (REVAND)
    ) u_rom (
        .word_idx (paddr[11:2]),
        .eco      (eco_q),
        .data     (rom_data)
    );

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            cnt_q             <= '0;
            pwrite_q          <= 1'b0;
            prdata_q          <= 8'h00;
            pready_q          <= 1'b1;
            pslverr_q         <= 1'b0;
            eco_q             <= 4'h0;
            capture_pending_q <= 1'b1;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            pwrite_q          <= pwrite_d;
            prdata_q          <= prdata_d;
            pready_q          <= pready_d;
            pslverr_q         <= pslverr_d;
            eco_q             <= eco_d;
            capture_pending_q <= capture_pending_d;
        end
    end

    // Next-state logic. A SETUP seen during ACCESS is ignored; dropping psel
    // in ACCESS aborts the transfer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (setup) state_d = ST_ACCESS;
            ST_ACCESS: if (!psel || cnt_q == '0) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Registered response. Outputs are computed one edge ahead, so pready
    // rises in the ACCESS cycle in which the counter reads zero.
    always_comb begin
        cnt_d     = cnt_q;
        pwrite_d  = pwrite_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (setup) begin
                    pwrite_d  = pwrite;
                    cnt_d     = WS_INIT;
                    prdata_d  = pwrite ? 8'h00 : rom_data;
                    pready_d  = (WS_INIT == '0);
                    pslverr_d = (WS_INIT == '0) & ERR_ON_WRITE & pwrite;
                end else begin
                    prdata_d  = 8'h00;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (!psel || cnt_q == '0) begin
                    cnt_d     = '0;
                    prdata_d  = 8'h00;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b0;
                end else begin
                    cnt_d     = cnt_q - 1'b1;
                    pready_d  = (cnt_q == WS_W'(1));
                    pslverr_d = (cnt_q == WS_W'(1)) & ERR_ON_WRITE & pwrite_q;
                end
            end
            default: begin
                cnt_d     = '0;
                prdata_d  = 8'h00;
                pready_d  = 1'b1;
                pslverr_d = 1'b0;
            end
        endcase
    end

    // ECO snapshot: captured only while IDLE so an in-flight read never sees
    // the nibble change. A new request wins over a capture on the same edge.
    always_comb begin
        eco_d             = eco_q;
        capture_pending_d = eco_resample | (capture_pending_q & (state_q != ST_IDLE));
        if (capture_pending_q && state_q == ST_IDLE) begin
            eco_d = ecorevnum;
        end
    end

    assign prdata  = {24'h0, prdata_q};
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_p_beid_peripheral_f0_id_reader.sv
// Scoreboard bench for the ID-space reader. Three instances with
// WAIT_STATES 0, 2 and 3 share the bus; only one is selected at a time.
module tb_p_beid_peripheral_f0_id_reader;

    localparam logic [11:0] PART = 12'h820;
    localparam logic [6:0]  JEP  = 7'h3B;
    localparam logic [3:0]  CONT = 4'h4;
    localparam logic [3:0]  REV  = 4'h0;
    localparam logic [3:0]  RAND = 4'h0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          waits;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  psel;
    logic        penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  ecorevnum;
    logic        eco_resample;
    logic [31:0] prdata [3];
    logic        pready [3];
    logic        pslverr [3];

    int n_cmp = 0;
    int n_err = 0;
    int cur = 0;
    bit acc = 1'b0;
    exp_t sb[$];
    logic [3:0] m_eco [3];
    bit         m_pend [3];
    int         ws_of [3] = '{0, 2, 3};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        p_beid_peripheral_f0_id_reader #(.WAIT_STATES((g == 0) ? 0 : g + 1)) u_dut (
            .clk          (clk),
            .reset        (reset),
            .psel         (psel[g]),
            .penable      (penable),
            .pwrite       (pwrite),
            .paddr        (paddr),
            .pwdata       (pwdata),
            .ecorevnum    (ecorevnum),
            .eco_resample (eco_resample),
            .prdata       (prdata[g]),
            .pready       (pready[g]),
            .pslverr      (pslverr[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ID map, written directly from the register table.
    function automatic logic [31:0] id_value(input logic [11:0] addr, input logic [3:0] eco);
        logic [11:0] a;
        a = {addr[11:2], 2'b00};
        case (a)
            12'hFD0: return {28'h0, CONT};
            12'hFE0: return {24'h0, PART[7:0]};
            12'hFE4: return {24'h0, JEP[3:0], PART[11:8]};
            12'hFE8: return {24'h0, REV, 1'b1, JEP[6:4]};
            12'hFEC: return {24'h0, eco, RAND};
            12'hFF0: return 32'h0D;
            12'hFF4: return 32'hF0;
            12'hFF8: return 32'h05;
            12'hFFC: return 32'hB1;
            default: return 32'h0;
        endcase
    endfunction

    // Advance one clock, updating the snapshot model from the inputs seen at
    // this edge: an idle instance with a pending request captures ecorevnum.
    task automatic tick();
        for (int d = 0; d < 3; d++) begin
            bit idle;
            idle = !(acc && d == cur);
            if (reset) begin
                m_eco[d]  = 4'h0;
                m_pend[d] = 1'b1;
            end else begin
                if (idle && m_pend[d]) m_eco[d] = ecorevnum;
                m_pend[d] = eco_resample || (m_pend[d] && !idle);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // One complete transfer. res_at: -1 = resample in SETUP, k >= 0 = in the
    // k-th ACCESS cycle, anything larger effectively never.
    task automatic xfer(input int d, input logic [11:0] addr, input bit wr,
                        input int res_at, input logic [3:0] new_eco, input string name);
        exp_t e;
        bit   done;
        cur = d;
        tick();
        psel      = 3'b000;
        psel[d]   = 1'b1;
        penable   = 1'b0;
        pwrite    = wr;
        paddr     = addr;
        pwdata    = $urandom;
        if (res_at == -1) begin
            ecorevnum    = new_eco;
            eco_resample = 1'b1;
        end
        e.data  = wr ? 32'h0 : id_value(addr, m_eco[d]);
        e.err   = wr;
        e.waits = ws_of[d];
        e.name  = name;
        sb.push_back(e);
        acc = 1'b0;
        tick();
        eco_resample = 1'b0;
        penable = 1'b1;
        acc     = 1'b1;
        done    = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            if (k == res_at) begin
                ecorevnum    = new_eco;
                eco_resample = 1'b1;
            end
            @(negedge clk);
            if (pready[d]) done = 1'b1;
            tick();
            eco_resample = 1'b0;
        end
        psel    = 3'b000;
        penable = 1'b0;
        acc     = 1'b0;
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: pready never rose within 8 ACCESS cycles", name);
        end
    endtask

    task automatic check_idle(input int d, input string name);
        check({name, "_pready"}, 32'(pready[d]), 32'h1);
        check({name, "_prdata"}, prdata[d], 32'h0);
        check({name, "_pslverr"}, 32'(pslverr[d]), 32'h0);
    endtask

    // Monitor: scores every completed ACCESS phase against the scoreboard.
    int wait_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (psel[cur] && penable) begin
            if (pready[cur]) begin
                if (sb.size() == 0) begin
                    check("unexpected_completion", 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_prdata"}, prdata[cur], e.data);
                    check({e.name, "_pslverr"}, 32'(pslverr[cur]), 32'(e.err));
                    check({e.name, "_waits"}, wait_cnt, e.waits);
                end
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; ecorevnum = 4'hA; eco_resample = 1'b0;
        for (int d = 0; d < 3; d++) begin
            m_eco[d] = 4'h0; m_pend[d] = 1'b1;
        end

        // 1: reset values, then first read picks up the captured nibble
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            for (int d = 0; d < 3; d++) check_idle(d, $sformatf("reset_c%0d_d%0d", c, d));
        end
        reset = 1'b0;
        xfer(0, 12'hFEC, 1'b0, 99, 4'h0, "t1_pid3");

        // 2: zero wait states
        xfer(0, 12'hFE0, 1'b0, 99, 4'h0, "t2_pid0");
        xfer(0, 12'hFE4, 1'b0, 99, 4'h0, "t2_pid1");
        xfer(0, 12'hFE8, 1'b0, 99, 4'h0, "t2_pid2");
        xfer(0, 12'hFF0, 1'b0, 99, 4'h0, "t2_cid0");
        xfer(0, 12'hFFC, 1'b0, 99, 4'h0, "t2_cid3");

        // 3: two wait states
        xfer(1, 12'hFD0, 1'b0, 99, 4'h0, "t3_pid4");

        // 4: write error, state unchanged, unmapped read
        xfer(0, 12'hFEC, 1'b1, 99, 4'h0, "t4_write");
        xfer(0, 12'hFEC, 1'b0, 99, 4'h0, "t4_pid3");
        xfer(0, 12'h100, 1'b0, 99, 4'h0, "t4_unmapped");
        xfer(1, 12'hFD6, 1'b0, 99, 4'h0, "t4_unaligned_pid5");

        // 5: resample mid-ACCESS is deferred
        xfer(2, 12'hFEC, 1'b0, 1, 4'h3, "t5_inflight");
        xfer(2, 12'hFEC, 1'b0, 99, 4'h0, "t5_after");

        // 6a: psel dropped during ACCESS
        cur = 1; tick();
        psel = 3'b010; penable = 1'b0; pwrite = 1'b0; paddr = 12'hFE0;
        tick();
        penable = 1'b1; acc = 1'b1;
        tick();
        psel = 3'b000; penable = 1'b0;
        tick();
        acc = 1'b0;
        @(negedge clk);
        check_idle(1, "t6_abort");
        xfer(1, 12'hFE4, 1'b0, 99, 4'h0, "t6_after_abort");

        // 6b: reset mid-transfer with psel still asserted
        cur = 2; tick();
        psel = 3'b100; penable = 1'b0; pwrite = 1'b0; paddr = 12'hFE8;
        tick();
        penable = 1'b1; acc = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; psel = 3'b000; penable = 1'b0; acc = 1'b0;
        @(negedge clk);
        check_idle(2, "t6_reset");
        xfer(2, 12'hFEC, 1'b0, 99, 4'h0, "t6_after_reset");

        // Randomised traffic, including resamples in SETUP and ACCESS
        for (int i = 0; i < 80; i++) begin
            int          d, ra;
            logic [11:0] a;
            d  = $urandom_range(0, 2);
            a  = ($urandom_range(0, 3) != 0) ? 12'(12'hFC0 + $urandom_range(0, 63))
                                             : 12'($urandom_range(0, 4095));
            ra = int'($urandom_range(0, 6)) - 1;
            xfer(d, a, ($urandom_range(0, 3) == 0), ra, 4'($urandom_range(0, 15)),
                 $sformatf("rnd%0d_a%03h", i, a));
        end

        repeat (3) tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
